// File: rtl/e_mdu_pkg.sv
// ============================================================================
// e_mdu_pkg -- shared pipeline constants: ALU/MDU opcodes and MDU latencies
// Rev 1.0
// ============================================================================
`default_nettype none

package e_mdu_pkg;

  localparam logic [3:0] ALU_add  = 4'd0;
  localparam logic [3:0] ALU_sub  = 4'd1;
  localparam logic [3:0] ALU_and  = 4'd2;
  localparam logic [3:0] ALU_or   = 4'd3;
  localparam logic [3:0] ALU_xor  = 4'd4;
  localparam logic [3:0] ALU_nor  = 4'd5;
  localparam logic [3:0] ALU_slt  = 4'd6;
  localparam logic [3:0] ALU_sltu = 4'd7;
  localparam logic [3:0] ALU_lui  = 4'd8;

  localparam logic [3:0] MDU_none  = 4'd0;
  localparam logic [3:0] MDU_mult  = 4'd1;
  localparam logic [3:0] MDU_multu = 4'd2;
  localparam logic [3:0] MDU_div   = 4'd3;
  localparam logic [3:0] MDU_divu  = 4'd4;
  localparam logic [3:0] MDU_mfhi  = 4'd5;
  localparam logic [3:0] MDU_mflo  = 4'd6;
  localparam logic [3:0] MDU_mthi  = 4'd7;
  localparam logic [3:0] MDU_mtlo  = 4'd8;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W        = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= MDU_mult) && (op <= MDU_divu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu_calc.sv
// ============================================================================
// e_mdu_calc -- combinational 64-bit product and quotient/remainder datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr_en
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_safe_mb;
  logic [31:0] w_safe_ub;
  logic [31:0] w_mq;
  logic [31:0] w_mr;

  assign w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_uprod = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; a zero divisor is replaced so the datapath
  // never produces X, the write is suppressed through wr_en instead.
  assign w_mag_a   = a[31] ? (32'd0 - a) : a;
  assign w_mag_b   = b[31] ? (32'd0 - b) : b;
  assign w_safe_mb = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_safe_ub = (b == 32'd0) ? 32'd1 : b;
  assign w_mq      = w_mag_a / w_safe_mb;
  assign w_mr      = w_mag_a % w_safe_mb;

  always_comb begin
    hi    = 32'd0;
    lo    = 32'd0;
    wr_en = 1'b0;
    case (op)
      MDU_mult: begin
        {hi, lo} = w_sprod;
        wr_en    = 1'b1;
      end
      MDU_multu: begin
        {hi, lo} = w_uprod;
        wr_en    = 1'b1;
      end
      MDU_div: begin
        lo    = (a[31] ^ b[31]) ? (32'd0 - w_mq) : w_mq;
        hi    = a[31] ? (32'd0 - w_mr) : w_mr;
        wr_en = (b != 32'd0);
      end
      MDU_divu: begin
        lo    = a / w_safe_ub;
        hi    = a % w_safe_ub;
        wr_en = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// e_mdu -- E-stage multiply/divide unit: latency FSM, cycle counter, HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDU_Ctr,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Result
);

  mdu_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [3:0]         r_op;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic [31:0]        w_hi;
  logic [31:0]        w_lo;
  logic               w_wr;

  e_mdu_calc u_calc (
    .a     (r_a),
    .b     (r_b),
    .op    (r_op),
    .hi    (w_hi),
    .lo    (w_lo),
    .wr_en (w_wr)
  );

  assign Busy  = (r_state == ST_RUN);
  assign Start = is_muldiv(MDU_Ctr) && !Busy;
  assign HI    = r_hi;
  assign LO    = r_lo;

  always_comb begin
    MDU_Result = 32'd0;
    if (MDU_Ctr == MDU_mfhi)      MDU_Result = r_hi;
    else if (MDU_Ctr == MDU_mflo) MDU_Result = r_lo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= MDU_none;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_a     <= SrcA;
            r_b     <= SrcB;
            r_op    <= MDU_Ctr;
            r_cnt   <= (MDU_Ctr == MDU_mult || MDU_Ctr == MDU_multu) ?
                       CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
            r_state <= ST_RUN;
          end else if (MDU_Ctr == MDU_mthi) begin
            r_hi <= SrcA;
          end else if (MDU_Ctr == MDU_mtlo) begin
            r_lo <= SrcA;
          end
        end
        ST_RUN: begin
          // Results land only on the final edge so mfhi/mflo see old values while busy.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            if (w_wr) begin
              r_hi <= w_hi;
              r_lo <= w_lo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// tb_e_mdu -- randomized bench for e_mdu against a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic [3:0]  MDU_Ctr = 4'd0;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_Result;

  int total = 0;
  int bad   = 0;

  e_mdu #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .MDU_Ctr    (MDU_Ctr),
    .Start      (Start),
    .Busy       (Busy),
    .HI         (HI),
    .LO         (LO),
    .MDU_Result (MDU_Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference result of an operation as {write_enable, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_op = 65'd0;
    case (op)
      MDU_mult:  begin q = sa * sb; ref_op = {1'b1, q}; end
      MDU_multu: begin p = ua * ub; ref_op = {1'b1, p}; end
      MDU_div:   if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        ref_op = {1'b1, r[31:0], q[31:0]};
      end
      MDU_divu:  if (b != 32'd0) begin
        p = ua / ub;
        q = longint'(ua % ub);
        ref_op = {1'b1, q[31:0], p[31:0]};
      end
      default: ;
    endcase
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [64:0] m_pend = 65'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_pend = 65'd0;
    end else if (m_left > 0) begin
      if (m_left == 1 && m_pend[64]) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
      m_left = m_left - 1;
    end else if (MDU_Ctr >= MDU_mult && MDU_Ctr <= MDU_divu) begin
      m_pend = ref_op(MDU_Ctr, SrcA, SrcB);
      m_left = (MDU_Ctr <= MDU_multu) ? ML : DL;
    end else if (MDU_Ctr == MDU_mthi) begin
      m_hi = SrcA;
    end else if (MDU_Ctr == MDU_mtlo) begin
      m_lo = SrcA;
    end
  end

  always @(negedge clk) begin
    logic        exp_start;
    logic [31:0] exp_res;
    exp_start = (MDU_Ctr >= MDU_mult && MDU_Ctr <= MDU_divu) && (m_left == 0);
    exp_res   = (MDU_Ctr == MDU_mfhi) ? m_hi : (MDU_Ctr == MDU_mflo) ? m_lo : 32'd0;
    check("busy",   {31'd0, Busy},  {31'd0, m_left > 0});
    check("start",  {31'd0, Start}, {31'd0, exp_start});
    check("hi",     HI, m_hi);
    check("lo",     LO, m_lo);
    check("result", MDU_Result, exp_res);
  end

  task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDU_Ctr = op;
    SrcA    = a;
    SrcB    = b;
    @(posedge clk);
    #1;
  endtask

  // Issue op, then count Busy cycles; optionally inject another opcode on busy cycle inj_at.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input logic [3:0] inj_op, output int n);
    MDU_Ctr = op;
    SrcA    = a;
    SrcB    = b;
    #1;
    check("start_accept", {31'd0, Start}, 32'd1);
    @(posedge clk);
    #1;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == inj_at) begin
        MDU_Ctr = inj_op;
        SrcA    = 32'h5555_AAAA;
        SrcB    = 32'd3;
        #1;
        check("start_while_busy", {31'd0, Start}, 32'd0);
      end else begin
        MDU_Ctr = MDU_none;
        SrcA    = $urandom;
        SrcB    = $urandom;
      end
      @(posedge clk);
      #1;
    end
    MDU_Ctr = MDU_none;
  endtask

  initial begin
    int n;
    int r;
    logic [3:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(MDU_mult, 32'hFFFF_FFFE, 32'd3, 0, MDU_none, n);
    check("mult_len", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    MDU_Ctr = MDU_mfhi;
    #1;
    check("mfhi_after_mult", MDU_Result, 32'hFFFF_FFFF);

    run_op(MDU_multu, 32'hFFFF_FFFE, 32'd3, 0, MDU_none, n);
    check("multu_len", 32'(n), 32'd5);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    run_op(MDU_div, 32'hFFFF_FFF9, 32'd2, 0, MDU_none, n);
    check("div_len", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    run_op(MDU_divu, 32'd7, 32'd0, 0, MDU_none, n);
    check("divu0_len", 32'(n), 32'd10);
    check("divu0_lo", LO, 32'hFFFF_FFFD);
    check("divu0_hi", HI, 32'hFFFF_FFFF);

    run_op(MDU_div, 32'd100, 32'd7, 3, MDU_mult, n);
    check("div_inj_len", 32'(n), 32'd10);
    check("div_inj_lo", LO, 32'd14);
    check("div_inj_hi", HI, 32'd2);

    cyc(MDU_mthi, 32'h1234_5678, 32'd0);
    check("mthi", HI, 32'h1234_5678);
    MDU_Ctr = MDU_mfhi;
    #1;
    check("mfhi", MDU_Result, 32'h1234_5678);

    run_op(MDU_mult, 32'd2, 32'd3, 2, MDU_mtlo, n);
    check("mtlo_busy_lo", LO, 32'd6);
    check("mtlo_busy_hi", HI, 32'd0);

    cyc(MDU_mult, 32'd3, 32'd5);
    repeat (3) cyc(MDU_none, 32'd0, 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (8) cyc(MDU_none, 32'd0, 32'd0);
    check("rst_no_write_hi", HI, 32'd0);
    check("rst_no_write_lo", LO, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      op = (r < 25) ? MDU_none : 4'($urandom_range(1, 15));
      a  = $urandom;
      r  = $urandom_range(0, 99);
      if (r < 12)      b = 32'd0;
      else if (r < 40) b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20))
                                                       : 32'd0 - 32'($urandom_range(1, 20));
      else             b = $urandom;
      if ($urandom_range(0, 19) == 0) a = 32'h8000_0000;
      MDU_Ctr = op;
      SrcA    = a;
      SrcB    = b;
      if ($urandom_range(0, 299) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    MDU_Ctr = MDU_none;
    repeat (12) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
